// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the iterative multiply/divide unit
package muldiv_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int REG_ZR    = 31;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULH = 2'b01,
        OP_UDIV  = 2'b10,
        OP_SDIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration on the {hi, lo} working pair
module muldiv_step #(
    parameter int WIDTH = 64
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum  = {1'b0, hi_i} + {1'b0, b_i};
        rem  = {hi_i, lo_i[WIDTH-1]};
        // rem < 2*b whenever hi < b, so the difference always fits in WIDTH bits
        diff = rem[WIDTH-1:0] - b_i;
        hi_o = hi_i;
        lo_o = lo_i;
        if (is_div_i) begin
            if (rem >= {1'b0, b_i}) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else if (lo_i[0]) begin
            {hi_o, lo_o} = {sum, lo_i[WIDTH-1:1]};
        end else begin
            {hi_o, lo_o} = {1'b0, hi_i, lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MUL/UMULH/UDIV/SDIV unit feeding the register write port
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int REG_ZR = muldiv_pkg::REG_ZR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [4:0]       dest,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       write_add,
    output logic             write_en
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       write_add_q, write_add_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we_q, we_d;

    op_e              op_in;
    logic             in_div;
    logic             in_sdiv;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign op_in   = op_e'(op);
    assign in_div  = op_in[1];
    assign in_sdiv = (op_in == OP_SDIV);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_q[1]),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        neg_d       = neg_q;
        divz_d      = divz_q;
        result_d    = result_q;
        write_add_d = write_add_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        we_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CALC;
                    op_d        = op_in;
                    count_d     = '0;
                    write_add_d = dest;
                    busy_d      = 1'b1;
                    hi_d        = '0;
                    lo_d        = opa;
                    b_d         = opb;
                    neg_d       = 1'b0;
                    divz_d      = in_div && (opb == '0);
                    // SDIV runs as an unsigned divide on magnitudes; the sign is restored in FIX
                    if (in_sdiv) begin
                        lo_d  = opa[WIDTH-1] ? -opa : opa;
                        b_d   = opb[WIDTH-1] ? -opb : opb;
                        neg_d = opa[WIDTH-1] ^ opb[WIDTH-1];
                    end
                end
            end
            CALC: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                unique case (op_q)
                    OP_MUL:   result_d = lo_q;
                    OP_UMULH: result_d = hi_q;
                    default: begin
                        if (divz_q) begin
                            result_d = '0;
                        end else if (neg_q) begin
                            result_d = -lo_q;
                        end else begin
                            result_d = lo_q;
                        end
                    end
                endcase
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                we_d    = (write_add_q != 5'(REG_ZR));
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            divz_q      <= 1'b0;
            result_q    <= '0;
            write_add_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            divz_q      <= divz_d;
            result_q    <= result_d;
            write_add_q <= write_add_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_q        <= we_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign write_add = write_add_q;
    assign write_en  = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W       = 64;
    localparam int LATENCY = 66;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   wa;
        logic         we;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic [4:0]   dest = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   write_add;
    logic         write_en;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    exp_t sb[$];

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .dest      (dest),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .write_add (write_add),
        .write_en  (write_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   minv;
        minv = {1'b1, {(W-1){1'b0}}};
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00: return p[W-1:0];
            2'b01: return p[2*W-1:W];
            2'b10: return (b == '0) ? '0 : a / b;
            default: begin
                if (b == '0) return '0;
                if (a == minv && b == {W{1'b1}}) return minv;
                return $signed(a) / $signed(b);
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: compares every completion against the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (write_en && !done) begin
                check("write_en_without_done", {63'b0, write_en}, '0);
            end
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_done", {63'b0, done}, '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("write_add", {59'b0, write_add}, {59'b0, e.wa});
                    check("write_en", {63'b0, write_en}, {63'b0, e.we});
                    check("latency", W'(cyc - e.acc), W'(LATENCY));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("completion_timeout", W'(sb.size()), '0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] d);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        dest  = d;
        @(posedge clk);
        #1;
        e.res = model(o, a, b);
        e.wa  = d;
        e.we  = (d != 5'd31);
        e.acc = cyc;
        sb.push_back(e);
        start = 1'b0;
        check("busy_after_accept", {63'b0, busy}, 64'd1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] d);
        issue(o, a, b, d);
        wait_idle();
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", {63'b0, busy}, '0);
        check("rst_done", {63'b0, done}, '0);
        check("rst_write_en", {63'b0, write_en}, '0);
        check("rst_result", result, '0);
        check("rst_write_add", {59'b0, write_add}, '0);

        run_op(2'b00, 64'd7, 64'd6, 5'd3);
        run_op(2'b01, {W{1'b1}}, 64'd2, 5'd4);
        run_op(2'b00, {W{1'b1}}, 64'd2, 5'd5);
        run_op(2'b11, -64'sd7, 64'd2, 5'd6);
        run_op(2'b10, 64'd100, 64'd7, 5'd7);
        run_op(2'b10, 64'd55, 64'd0, 5'd8);
        run_op(2'b11, -64'sd55, 64'd0, 5'd9);
        run_op(2'b11, 64'h8000_0000_0000_0000, {W{1'b1}}, 5'd10);

        // XZR destination, with a stray start mid-operation that must be ignored
        base = done_seen;
        issue(2'b00, 64'd3, 64'd3, 5'd31);
        repeat (10) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        opa   = 64'd1000;
        opb   = 64'd10;
        dest  = 5'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (80) @(negedge clk);
        check("single_done_pulse", W'(done_seen - base), 64'd1);

        // reset mid-operation drops the in-flight op
        base = done_seen;
        issue(2'b00, 64'd11, 64'd13, 5'd2);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check("busy_after_reset", {63'b0, busy}, '0);
        check("done_after_reset", {63'b0, done}, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check("no_done_after_reset", W'(done_seen - base), '0);
        run_op(2'b10, 64'd9, 64'd3, 5'd12);

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), rand_operand(), rand_operand(),
                   5'($urandom_range(0, 31)));
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 64-bit multiply/divide execution unit for the LEGv8 datapath, directly downstream of the register file.
- Consumes the two register read operands and produces a result, destination address and write enable for the register write port.
- Handles MUL, UMULH, UDIV and SDIV, which are too large for the single-cycle ALU. Uses a radix-2 shift-add / shift-subtract loop with a start/busy/done handshake.

Parameters:
- WIDTH, 64, operand/result width; iteration count equals WIDTH.
- REG_ZR, 31, register index of XZR; writes to it are suppressed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; returns unit to IDLE
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low 64 of product), 01 UMULH (high 64, unsigned), 10 UDIV, 11 SDIV
- opa  in  WIDTH  operand Rn (register file read_1)
- opb  in  WIDTH  operand Rm (register file read_2)
- dest  in  5  destination register Rd
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  operation result; held until next acceptance
- write_add  out  5  Rd captured at acceptance
- write_en  out  1  done AND (write_add != REG_ZR)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; busy, done, write_en=0; result=0; write_add=0; all internal registers cleared.
- States:
  - IDLE: start=1 latches op, dest, opa, opb and goes to CALC; count=0.
  - CALC: one iteration per cycle; after WIDTH iterations (count==WIDTH-1) goes to FIX.
  - FIX: sign and zero correction, loads result; goes to DONE.
  - DONE: done=1 (and write_en if applicable) for exactly one cycle; returns to IDLE.
- Latency: acceptance at edge E gives done high in the cycle after edge E+WIDTH+2, i.e. 66 cycles for WIDTH=64. Latency is fixed and independent of operand values.
- start while busy or in DONE: ignored, with no side effect. Back-to-back operation is possible: start may be accepted in the IDLE cycle immediately after done.
- Multiply:
  - Unsigned shift-add into a 2*WIDTH product register.
  - MUL returns product[WIDTH-1:0], which is correct for signed and unsigned operands.
  - UMULH returns product[2*WIDTH-1:WIDTH].
- UDIV: restoring division; quotient returned; remainder discarded.
- SDIV:
  - Operands converted to magnitude at acceptance; division is unsigned.
  - In FIX, the quotient is negated if sign(opa) XOR sign(opb). Truncation is toward zero.
- Division by zero (opb==0, UDIV or SDIV): result=0. Full latency is still taken and no exception is raised.
- SDIV overflow (opa=0x8000_0000_0000_0000, opb=-1): result=0x8000_0000_0000_0000 (two's-complement wrap).
- dest==REG_ZR: done still pulses; write_en stays 0; result still updated.
- Reset mid-operation: the next edge with reset=1 forces IDLE. The in-flight op is lost and no done pulse is produced.
- write_en is asserted exactly one cycle per accepted op with dest!=REG_ZR, never otherwise.

Decomposition:
- Package muldiv_pkg:
  - op encodings: OP_MUL, OP_UMULH, OP_UDIV, OP_SDIV.
  - state enum: IDLE, CALC, FIX, DONE.
  - constants WIDTH_DEF=64, REG_ZR=31.
- Sub-module muldiv_step (combinational): one iteration of shift-add or shift-subtract on the {hi, lo} working register pair. Instantiated once and selected by op class.

Test Plan:
- MUL opa=7, opb=6, dest=3 -> done at cycle 66 after acceptance; result=42; write_add=3; write_en=1 for one cycle.
- UMULH opa=0xFFFF_FFFF_FFFF_FFFF, opb=2 -> result=1. MUL with the same operands -> result=0xFFFF_FFFF_FFFF_FFFE.
- SDIV opa=-7, opb=2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD). UDIV 100/7 -> result=14.
- UDIV and SDIV with opb=0 -> result=0 after 66 cycles. SDIV 0x8000_0000_0000_0000 / -1 -> result=0x8000_0000_0000_0000.
- dest=31, MUL 3*3 -> done=1, write_en=0, result=9. A second start pulsed mid-operation -> ignored; only one done pulse.
- Start MUL, assert reset at cycle 20 -> busy=0 next cycle, no done. A new UDIV 9/3 afterwards -> result=3 with full latency.
